// File: rtl/rr_holding_arbiter_if.sv
// Requester and consumer side of the round-robin holding arbiter.
// Valid/ready: a word moves on a rising edge only when its valid and ready are both 1 at that edge.
interface rr_holding_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       ReqValid;
  logic [NREQ*WIDTH-1:0] ReqData;
  logic [NREQ-1:0]       ReqReady;
  logic                  OutValid;
  logic [WIDTH-1:0]      OutData;
  logic [IDW-1:0]        OutGrantId;
  logic                  OutReady;

  // master: requesters plus consumer; slave: the arbiter itself
  modport master (
    output ReqValid, ReqData, OutReady,
    input  ReqReady, OutValid, OutData, OutGrantId
  );

  modport slave (
    input  ReqValid, ReqData, OutReady,
    output ReqReady, OutValid, OutData, OutGrantId
  );
endinterface

// File: rtl/rr_holding_arbiter.sv
// Round-robin arbiter feeding one holding register; sustains one transfer per cycle.
module rr_holding_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rr_holding_arbiter_if.slave   bus,
  output logic                  dbg_state_o,
  output logic [IDW-1:0]        dbg_ptr_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   gid_q;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic [IDW-1:0]   win;
  logic             any;
  logic             accept;
  logic [IDW:0]     cand;
  logic [NREQ-1:0]  grant_vec;

  // Scan from the highest offset down so the lowest offset from ptr_q wins.
  always_comb begin
    win  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (bus.ReqValid[cand[IDW-1:0]]) begin
        win = cand[IDW-1:0];
        any = 1'b1;
      end
    end
  end

  assign accept = (state_q == EMPTY) | bus.OutReady;

  // Gated by reset_n so no requester sees a grant while the arbiter is held in reset.
  always_comb begin
    grant_vec      = '0;
    grant_vec[win] = accept & any & reset_n;
  end

  assign data_d = bus.ReqData[win*WIDTH +: WIDTH];
  assign ptr_d  = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (any) begin
            state_q <= FULL;
            data_q  <= data_d;
            gid_q   <= win;
            ptr_q   <= ptr_d;
          end
        end
        FULL: begin
          if (bus.OutReady) begin
            if (any) begin
              data_q <= data_d;
              gid_q  <= win;
              ptr_q  <= ptr_d;
            end else begin
              // Stale data and id are left in place; they are meaningless while empty.
              state_q <= EMPTY;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign bus.ReqReady   = grant_vec;
  assign bus.OutValid   = (state_q == FULL);
  assign bus.OutData    = data_q;
  assign bus.OutGrantId = gid_q;
  assign dbg_state_o    = state_q;
  assign dbg_ptr_o      = ptr_q;

endmodule

// File: tb/tb_rr_holding_arbiter.sv
// Directed bench for rr_holding_arbiter: a 4-requester instance and a 3-requester instance.
module tb_rr_holding_arbiter;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  rr_holding_arbiter_if #(.NREQ(4), .WIDTH(32)) if4 ();
  rr_holding_arbiter_if #(.NREQ(3), .WIDTH(32)) if3 ();

  logic       st4, st3;
  logic [1:0] ptr4, ptr3;

  rr_holding_arbiter #(.NREQ(4), .WIDTH(32)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .bus(if4), .dbg_state_o(st4), .dbg_ptr_o(ptr4)
  );

  rr_holding_arbiter #(.NREQ(3), .WIDTH(32)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .bus(if3), .dbg_state_o(st3), .dbg_ptr_o(ptr3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] lane_word(int i);
    return 32'hD000_0000 + 32'(i);
  endfunction

  task automatic load_lanes4();
    for (int i = 0; i < 4; i++) if4.ReqData[i*32 +: 32] = lane_word(i);
  endtask

  // drivers and scenarios
  task automatic test_reset();
    reset_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if4.ReqValid = 4'($urandom_range(0, 15));
      if4.ReqData  = {$urandom, $urandom, $urandom, $urandom};
      if4.OutReady = 1'($urandom_range(0, 1));
      step();
      n_checks++;
      if (if4.OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid got %0b want 0", if4.OutValid); end
      n_checks++;
      if (if4.OutData !== 32'h0) begin n_fail++; $display("FAIL reset_outdata got %h want 0", if4.OutData); end
      n_checks++;
      if (if4.OutGrantId !== 2'd0) begin n_fail++; $display("FAIL reset_gid got %0d want 0", if4.OutGrantId); end
      n_checks++;
      if (if4.ReqReady !== 4'b0000) begin n_fail++; $display("FAIL reset_reqready got %b want 0000", if4.ReqReady); end
    end
    if4.ReqValid = '0;
    if4.OutReady = 1'b0;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    if4.ReqData               = '0;
    if4.ReqData[0*32 +: 32]   = 32'h1111_0000;
    if4.ReqData[2*32 +: 32]   = 32'hA5A5_0002;
    if4.ReqValid              = 4'b0100;
    if4.OutReady              = 1'b1;
    #1;
    n_checks++;
    if (if4.ReqReady !== 4'b0100) begin n_fail++; $display("FAIL single_reqready got %b want 0100", if4.ReqReady); end
    step();
    n_checks++;
    if (if4.OutValid !== 1'b1) begin n_fail++; $display("FAIL single_outvalid got %0b want 1", if4.OutValid); end
    n_checks++;
    if (if4.OutData !== 32'hA5A5_0002) begin n_fail++; $display("FAIL single_outdata got %h want a5a50002", if4.OutData); end
    n_checks++;
    if (if4.OutGrantId !== 2'd2) begin n_fail++; $display("FAIL single_gid got %0d want 2", if4.OutGrantId); end
    n_checks++;
    if (ptr4 !== 2'd3) begin n_fail++; $display("FAIL single_ptr got %0d want 3", ptr4); end
    if4.ReqValid = 4'b0000;
    step();
    n_checks++;
    if (if4.OutValid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %0b want 0", if4.OutValid); end
  endtask

  task automatic test_ptr_skip_and_drain();
    if4.ReqData             = '0;
    if4.ReqData[1*32 +: 32] = 32'h0000_BEE1;
    if4.ReqData[0*32 +: 32] = 32'h0000_CAF0;
    if4.ReqValid            = 4'b0010;
    #1;
    n_checks++;
    if (if4.ReqReady !== 4'b0010) begin n_fail++; $display("FAIL skip_reqready got %b want 0010", if4.ReqReady); end
    step();
    n_checks++;
    if (if4.OutGrantId !== 2'd1) begin n_fail++; $display("FAIL skip_gid got %0d want 1", if4.OutGrantId); end
    n_checks++;
    if (ptr4 !== 2'd2) begin n_fail++; $display("FAIL skip_ptr got %0d want 2", ptr4); end
    if4.ReqValid = 4'b0000;
    step();
    n_checks++;
    if (if4.OutValid !== 1'b0) begin n_fail++; $display("FAIL drain_outvalid got %0b want 0", if4.OutValid); end
    n_checks++;
    if (ptr4 !== 2'd2) begin n_fail++; $display("FAIL drain_ptr got %0d want 2", ptr4); end
    step();
    n_checks++;
    if (ptr4 !== 2'd2) begin n_fail++; $display("FAIL idle_ptr got %0d want 2", ptr4); end
    if4.ReqValid = 4'b0001;
    step();
    n_checks++;
    if (if4.OutValid !== 1'b1 || if4.OutGrantId !== 2'd0 || if4.OutData !== 32'h0000_CAF0) begin
      n_fail++;
      $display("FAIL refill got v=%0b id=%0d d=%h want v=1 id=0 d=0000caf0", if4.OutValid, if4.OutGrantId, if4.OutData);
    end
    n_checks++;
    if (ptr4 !== 2'd1) begin n_fail++; $display("FAIL refill_ptr got %0d want 1", ptr4); end
    if4.ReqValid = 4'b0000;
    step();
  endtask

  task automatic test_rotation();
    do_reset();
    load_lanes4();
    if4.ReqValid = 4'b1111;
    if4.OutReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (if4.ReqReady !== (4'b0001 << (i % 4))) begin
        n_fail++; $display("FAIL rot_reqready[%0d] got %b want %b", i, if4.ReqReady, 4'b0001 << (i % 4));
      end
      step();
      n_checks++;
      if (if4.OutValid !== 1'b1 || if4.OutGrantId !== 2'(i % 4) || if4.OutData !== lane_word(i % 4)) begin
        n_fail++;
        $display("FAIL rot_out[%0d] got v=%0b id=%0d d=%h want v=1 id=%0d d=%h",
                 i, if4.OutValid, if4.OutGrantId, if4.OutData, i % 4, lane_word(i % 4));
      end
    end
  endtask

  task automatic test_backpressure();
    step();
    step();
    n_checks++;
    if (if4.OutGrantId !== 2'd1) begin n_fail++; $display("FAIL bp_setup_gid got %0d want 1", if4.OutGrantId); end
    if4.OutReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if4.ReqValid = (c % 2 == 0) ? 4'b1111 : 4'b0101;
      #1;
      n_checks++;
      if (if4.ReqReady !== 4'b0000) begin n_fail++; $display("FAIL bp_reqready[%0d] got %b want 0000", c, if4.ReqReady); end
      step();
      n_checks++;
      if (if4.OutValid !== 1'b1 || if4.OutGrantId !== 2'd1 || if4.OutData !== lane_word(1) || ptr4 !== 2'd2) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got v=%0b id=%0d d=%h p=%0d want v=1 id=1 d=%h p=2",
                 c, if4.OutValid, if4.OutGrantId, if4.OutData, ptr4, lane_word(1));
      end
    end
    if4.ReqValid = 4'b1111;
    if4.OutReady = 1'b1;
    #1;
    n_checks++;
    if (if4.ReqReady !== 4'b0100) begin n_fail++; $display("FAIL bp_release_reqready got %b want 0100", if4.ReqReady); end
    step();
    n_checks++;
    if (if4.OutGrantId !== 2'd2 || if4.OutData !== lane_word(2)) begin
      n_fail++; $display("FAIL bp_release got id=%0d d=%h want id=2 d=%h", if4.OutGrantId, if4.OutData, lane_word(2));
    end
  endtask

  task automatic test_reset_mid();
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (if4.OutValid !== 1'b0) begin n_fail++; $display("FAIL async_reset_outvalid got %0b want 0", if4.OutValid); end
    n_checks++;
    if (if4.ReqReady !== 4'b0000) begin n_fail++; $display("FAIL async_reset_reqready got %b want 0000", if4.ReqReady); end
    step();
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (if4.ReqReady !== 4'b0001) begin n_fail++; $display("FAIL post_reset_reqready got %b want 0001", if4.ReqReady); end
    step();
    n_checks++;
    if (if4.OutValid !== 1'b1 || if4.OutGrantId !== 2'd0) begin
      n_fail++; $display("FAIL post_reset_grant got v=%0b id=%0d want v=1 id=0", if4.OutValid, if4.OutGrantId);
    end
    if4.ReqValid = 4'b0000;
    step();
  endtask

  task automatic test_nreq3_wrap();
    logic [1:0] exp_ptr;
    for (int i = 0; i < 3; i++) if3.ReqData[i*32 +: 32] = lane_word(i + 8);
    if3.ReqValid = 3'b111;
    if3.OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_ptr = 2'((i % 3 + 1) % 3);
      n_checks++;
      if (if3.OutValid !== 1'b1 || if3.OutGrantId !== 2'(i % 3) || if3.OutData !== lane_word(i % 3 + 8)) begin
        n_fail++;
        $display("FAIL n3_grant[%0d] got v=%0b id=%0d d=%h want v=1 id=%0d d=%h",
                 i, if3.OutValid, if3.OutGrantId, if3.OutData, i % 3, lane_word(i % 3 + 8));
      end
      n_checks++;
      if (ptr3 !== exp_ptr) begin n_fail++; $display("FAIL n3_ptr[%0d] got %0d want %0d", i, ptr3, exp_ptr); end
    end
    if3.ReqValid = 3'b000;
    step();
    n_checks++;
    if (if3.OutValid !== 1'b0) begin n_fail++; $display("FAIL n3_drain got %0b want 0", if3.OutValid); end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    if4.ReqValid = '0;
    if4.ReqData  = '0;
    if4.OutReady = 1'b0;
    if3.ReqValid = '0;
    if3.ReqData  = '0;
    if3.OutReady = 1'b0;
    step();
    test_reset();
    test_single();
    test_ptr_skip_and_drain();
    test_rotation();
    test_backpressure();
    test_reset_mid();
    test_nreq3_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
